// File: rtl/parity_bank_writer.sv
// parity_bank_writer
// Write-side controller for a two-bank, even-parity word memory.
// 16 words of {data, parity}; addr[3] selects the bank, the low bits select
// the word. Each accepted write is stored, then read back and verified.
// After every reset the whole memory is cleared before requests are taken.
module parity_bank_writer #(
  parameter int unsigned DEPTH_PER_BANK = 8,
  parameter int unsigned DATA_W         = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [3:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              inj_perr,
  output logic              wr_done,
  output logic              err,
  output logic [3:0]        err_addr,
  input  logic [3:0]        rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_parity,
  output logic              rd_perr,
  output logic              init_done
);

  localparam int unsigned IDX_W  = $clog2(DEPTH_PER_BANK);
  localparam int unsigned WORD_W = DATA_W + 1;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    IDLE   = 2'd1,
    WRITE  = 2'd2,
    VERIFY = 2'd3
  } state_t;

  state_t state;

  // Clear counter and captured request
  logic [3:0]        cnt;
  logic [3:0]        cap_addr;
  logic [DATA_W-1:0] cap_data;
  logic              cap_par;

  // Storage: word layout {data, parity}, parity at bit 0
  logic [WORD_W-1:0] bank1 [DEPTH_PER_BANK];
  logic [WORD_W-1:0] bank2 [DEPTH_PER_BANK];

  // Shared write port into the banks
  logic              mem_we;
  logic [3:0]        mem_waddr;
  logic [WORD_W-1:0] mem_wdata;

  // Read-back path used during VERIFY
  logic [WORD_W-1:0] ver_word;
  logic              verify_bad;

  // Read port word
  logic [WORD_W-1:0] rd_word;

  // Select the write source: clearing during INIT, captured request in WRITE
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    case (state)
      INIT: begin
        mem_we    = 1'b1;
        mem_waddr = cnt;
        mem_wdata = '0;
      end
      WRITE: begin
        mem_we    = 1'b1;
        mem_waddr = cap_addr;
        mem_wdata = {cap_data, cap_par};
      end
      default: begin
        mem_we    = 1'b0;
      end
    endcase
  end

  // Bank storage; contents are not reset, INIT clears them instead
  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (mem_waddr[3]) begin
        bank2[mem_waddr[IDX_W-1:0]] <= mem_wdata;
      end else begin
        bank1[mem_waddr[IDX_W-1:0]] <= mem_wdata;
      end
    end
  end

  // Read back the captured address and check data and even parity
  always_comb begin
    ver_word   = cap_addr[3] ? bank2[cap_addr[IDX_W-1:0]]
                             : bank1[cap_addr[IDX_W-1:0]];
    verify_bad = (ver_word[WORD_W-1:1] != cap_data) ||
                 (ver_word[0] != (^cap_data));
  end

  // Combinational fetch-side read port, no write bypass
  always_comb begin
    rd_word   = rd_addr[3] ? bank2[rd_addr[IDX_W-1:0]]
                           : bank1[rd_addr[IDX_W-1:0]];
    rd_data   = rd_word[WORD_W-1:1];
    rd_parity = rd_word[0];
    rd_perr   = rd_word[0] ^ (^rd_word[WORD_W-1:1]);
  end

  // Control FSM with registered handshake and status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= INIT;
      cnt       <= '0;
      wr_ready  <= 1'b0;
      wr_done   <= 1'b0;
      err       <= 1'b0;
      err_addr  <= '0;
      init_done <= 1'b0;
      cap_addr  <= '0;
      cap_data  <= '0;
      cap_par   <= 1'b0;
    end else begin
      wr_done <= 1'b0;
      case (state)
        INIT: begin
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            state     <= IDLE;
            init_done <= 1'b1;
            wr_ready  <= 1'b1;
          end
        end
        IDLE: begin
          if (wr_valid) begin
            cap_addr <= wr_addr;
            cap_data <= wr_data;
            cap_par  <= (^wr_data) ^ inj_perr;
            wr_ready <= 1'b0;
            state    <= WRITE;
          end
        end
        WRITE: begin
          state <= VERIFY;
        end
        VERIFY: begin
          if (verify_bad) begin
            err      <= 1'b1;
            err_addr <= cap_addr;
          end
          wr_done  <= 1'b1;
          wr_ready <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          state <= INIT;
        end
      endcase
    end
  end

endmodule
